// File: rtl/piso_serial_tx_module_pkg.sv
// Shared types and line levels for the PISO serial transmitter.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/piso_serial_tx_module_bit_tick_gen.sv
// Bit-period counter: tick is high on the last clock of each serial bit.
module bit_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/piso_serial_tx_module.sv
// Frame transmitter: start bit, DATA_WIDTH bits LSB first, stop bit.
module piso_serial_tx_module
    import tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load,
    output logic                  ready,
    output logic                  busy,
    output logic                  tx_out,
    output logic                  done
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  tick, tick_clear;

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(tick_clear),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        tick_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d    = data_in;
                    tick_clear = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so it changes on the same edge.
        tx_d = IDLE_LEVEL;
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = STOP_BIT;
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= IDLE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign busy   = ~ready;
    assign tx_out = tx_q;
    assign done   = done_q;

endmodule

// File: tb/tb_piso_serial_tx_module.sv
// Directed bench for the PISO transmitter with a per-cycle expected line-level queue.
module tb_piso_serial_tx_module;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       load;
    logic       ready, busy, tx_out, done;
    logic [3:0] data1;
    logic       load1;
    logic       ready1, busy1, tx1, done1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic        exp_q[$];

    piso_serial_tx_module #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(4)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_in(data_in),
        .load   (load),
        .ready  (ready),
        .busy   (busy),
        .tx_out (tx_out),
        .done   (done)
    );

    piso_serial_tx_module #(
        .DATA_WIDTH  (4),
        .CLKS_PER_BIT(1)
    ) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_in(data1),
        .load   (load1),
        .ready  (ready1),
        .busy   (busy1),
        .tx_out (tx1),
        .done   (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic get(input bit sel, output logic t, output logic b, output logic r, output logic d);
        if (sel) begin
            t = tx1; b = busy1; r = ready1; d = done1;
        end else begin
            t = tx_out; b = busy; r = ready; d = done;
        end
    endtask

    task automatic push_frame(input logic [31:0] d, input int unsigned dw, input int unsigned cpb);
        for (int unsigned i = 0; i < cpb; i++) exp_q.push_back(1'b0);
        for (int unsigned b = 0; b < dw; b++)
            for (int unsigned i = 0; i < cpb; i++) exp_q.push_back(d[b]);
        for (int unsigned i = 0; i < cpb; i++) exp_q.push_back(1'b1);
    endtask

    task automatic chk_idle(input string tag, input bit sel);
        logic t, b, r, d;
        get(sel, t, b, r, d);
        chk({tag, "_tx"}, t, 1'b1);
        chk({tag, "_ready"}, r, 1'b1);
        chk({tag, "_busy"}, b, 1'b0);
        chk({tag, "_done"}, d, 1'b0);
    endtask

    // Walks the queued frame one cycle at a time, optionally pulsing load at cycle inj_cycle,
    // then checks the done cycle that must follow the stop bit.
    task automatic drain(input string tag, input bit sel, input int inj_cycle, input logic [7:0] inj_data);
        logic t, b, r, d, e;
        int cyc = 0;
        while (exp_q.size() > 0) begin
            cyc++;
            e = exp_q.pop_front();
            get(sel, t, b, r, d);
            chk({tag, "_tx"}, t, e);
            chk({tag, "_busy"}, b, 1'b1);
            chk({tag, "_done"}, d, 1'b0);
            if (cyc == inj_cycle) begin
                load    = 1'b1;
                data_in = inj_data;
            end else begin
                load = 1'b0;
            end
            step();
        end
        get(sel, t, b, r, d);
        chk({tag, "_done_pulse"}, d, 1'b1);
        chk({tag, "_done_ready"}, r, 1'b1);
        chk({tag, "_done_busy"}, b, 1'b0);
        chk({tag, "_done_tx"}, t, 1'b1);
    endtask

    initial begin
        logic t, b, r, d, e;
        rst_n   = 1'b0;
        load    = 1'b1;
        data_in = 8'hA5;
        load1   = 1'b0;
        data1   = 4'h0;

        // reset held with load asserted
        repeat (3) begin
            step();
            chk_idle("reset", 1'b0);
            chk_idle("reset1", 1'b1);
        end
        rst_n = 1'b1;
        load  = 1'b0;
        repeat (3) begin
            step();
            chk_idle("post_reset", 1'b0);
        end

        // single frame 8'hA5
        data_in = 8'hA5;
        load    = 1'b1;
        step();
        load = 1'b0;
        push_frame(32'hA5, 8, 4);
        drain("a5", 1'b0, -1, 8'h00);

        // load ignored while busy
        step();
        data_in = 8'h3C;
        load    = 1'b1;
        step();
        load = 1'b0;
        push_frame(32'h3C, 8, 4);
        drain("busy_load", 1'b0, 10, 8'hFF);
        repeat (5) begin
            step();
            chk_idle("no_second", 1'b0);
        end

        // back-to-back: new load in the done cycle
        data_in = 8'hC3;
        load    = 1'b1;
        step();
        load = 1'b0;
        push_frame(32'hC3, 8, 4);
        drain("b2b_first", 1'b0, -1, 8'h00);
        data_in = 8'h01;
        load    = 1'b1;
        step();
        load = 1'b0;
        push_frame(32'h01, 8, 4);
        drain("b2b_second", 1'b0, -1, 8'h00);

        // reset during data bit 3
        step();
        data_in = 8'hA5;
        load    = 1'b1;
        step();
        load = 1'b0;
        push_frame(32'hA5, 8, 4);
        for (int i = 0; i < 18; i++) begin
            e = exp_q.pop_front();
            get(1'b0, t, b, r, d);
            chk("pre_abort_tx", t, e);
            chk("pre_abort_busy", b, 1'b1);
            step();
        end
        exp_q.delete();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_idle("abort", 1'b0);
        repeat (3) begin
            step();
            chk_idle("abort_idle", 1'b0);
        end
        data_in = 8'h96;
        load    = 1'b1;
        step();
        load = 1'b0;
        push_frame(32'h96, 8, 4);
        drain("after_abort", 1'b0, -1, 8'h00);

        // CLKS_PER_BIT=1, DATA_WIDTH=4 instance
        data1 = 4'b1001;
        load1 = 1'b1;
        step();
        load1 = 1'b0;
        push_frame(32'h9, 4, 1);
        drain("cpb1", 1'b1, -1, 8'h00);
        step();
        chk_idle("cpb1_idle", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
